// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU: registered single-cycle ops, iterative multiply/divide
// One op in flight; results and flags are held in DONE until the consumer takes them.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             z,
    output logic             v,
    output logic             n,
    output logic             dbz
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_SLT  = 5'b00010;
    localparam logic [4:0] OP_SLTU = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01001;
    localparam logic [4:0] OP_XOR  = 5'b01010;
    localparam logic [4:0] OP_NOR  = 5'b01011;
    localparam logic [4:0] OP_SLL  = 5'b10000;
    localparam logic [4:0] OP_SRL  = 5'b10001;
    localparam logic [4:0] OP_SRA  = 5'b10010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [4:0]         op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               z_q, z_d, v_q, v_d, n_q, n_d, dbz_q, dbz_d;

    logic [WIDTH-1:0]   sc_y;
    logic               sc_v;
    logic [WIDTH-1:0]   sum, diff;
    logic [SHW-1:0]     sh;

    assign sum  = A + B;
    assign diff = A - B;
    assign sh   = B[SHW-1:0];

    always_comb begin
        sc_y = '0;
        sc_v = 1'b0;
        case (ALUOp)
            OP_ADD: begin
                sc_y = sum;
                sc_v = (A[WIDTH-1] == B[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_y = diff;
                sc_v = (A[WIDTH-1] != B[WIDTH-1]) & (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  sc_y = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SLTU: sc_y = {{(WIDTH-1){1'b0}}, A < B};
            OP_AND:  sc_y = A & B;
            OP_OR:   sc_y = A | B;
            OP_XOR:  sc_y = A ^ B;
            OP_NOR:  sc_y = ~(A | B);
            OP_SLL:  sc_y = A << sh;
            OP_SRL:  sc_y = A >> sh;
            OP_SRA:  sc_y = $signed(A) >>> sh;
            default: sc_y = '0;
        endcase
    end

    // Multiply: acc = {partial product, remaining multiplier bits}, opnd = multiplicand.
    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_add  = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient}, opnd = divisor.
    // A borrow out of the trial subtraction means the shifted remainder is below the divisor.
    logic [WIDTH:0]     div_sh, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_ge   = ~div_diff[WIDTH];
    assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] iter_next;
    assign iter_next = op_q[1] ? div_next : mul_next;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        y_d     = y_q;
        z_d     = z_q;
        v_d     = v_q;
        n_d     = n_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = ALUOp;
                    if (ALUOp[4:2] == 3'b110) begin
                        if (ALUOp[1] && (B == '0)) begin
                            state_d = DONE;
                            y_d     = ALUOp[0] ? A : {WIDTH{1'b1}};
                            v_d     = 1'b0;
                            dbz_d   = 1'b1;
                        end else begin
                            state_d = BUSY;
                            cnt_d   = SHW'(WIDTH - 1);
                            opnd_d  = ALUOp[1] ? B : A;
                            acc_d   = {{WIDTH{1'b0}}, (ALUOp[1] ? A : B)};
                        end
                    end else begin
                        state_d = DONE;
                        y_d     = sc_y;
                        v_d     = sc_v;
                        dbz_d   = 1'b0;
                    end
                end
            end
            BUSY: begin
                acc_d = iter_next;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    y_d     = op_q[0] ? iter_next[2*WIDTH-1:WIDTH] : iter_next[WIDTH-1:0];
                    v_d     = 1'b0;
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if ((state_d == DONE) && (state_q != DONE)) begin
            z_d = (y_d == '0);
            n_d = y_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            z_q     <= z_d;
            v_q     <= v_d;
            n_q     <= n_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Y         = y_q;
    assign z         = z_q;
    assign v         = v_q;
    assign n         = n_q;
    assign dbz       = dbz_q;
endmodule
